prbs_qpsk_ber_checker: RTL
==========================

Name: prbs_qpsk_ber_checker

Overview:
- Sits directly downstream of channel_with_noise and consumes its Out_I/Out_Q samples.
- Slices each sample to a hard QPSK decision and self-synchronises a PRBS9 reference to the received bit stream.
- Once in lock, counts checked bits and bit errors, giving a hardware BER measurement of the link at the programmed sigma_scale.
- Upstream transmitter maps PRBS9 (x^9+x^5+1) two bits per symbol: first bit on I, second bit on Q; bit 1 maps to a negative sample.

Parameters:
- DWIDTH, 9, width of signed input samples (matches channel output).
- CNT_W, 32, width of bit and error counters.
- LOAD_SYM, 5, valid symbols used to fill the 9-bit reference register (10 bits >= 9).
- LOCK_CNT, 16, consecutive error-free symbols required to declare lock.
- WIN_LEN, 256, symbols per loss-of-lock supervision window.
- ERR_THR, 16, bit errors in one window above which lock is dropped.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous reset, active-low (asserted when 0).
- in_valid  in  1  In_I/In_Q carry a symbol this cycle.
- In_I  in  DWIDTH  signed I sample from channel.
- In_Q  in  DWIDTH  signed Q sample from channel.
- clear  in  1  synchronous clear of bit_cnt and err_cnt; does not affect lock state.
- locked  out  1  checker is in LOCKED state.
- bit_cnt  out  CNT_W  bits compared while locked, saturating.
- err_cnt  out  CNT_W  bit errors while locked, saturating.
- loss_pulse  out  1  one-cycle pulse when LOCKED drops to SEARCH.

Behaviour:
- Reset (rst==0 on a clk edge): state=SEARCH, reference register s=0, all internal counters=0, locked=0, bit_cnt=0, err_cnt=0, loss_pulse=0. Reset overrides every other input, including mid-lock.
- Slicer: bI = In_I[DWIDTH-1] (sign bit), bQ = In_Q[DWIDTH-1]. Zero slices to 0.
- Reference register: s[0] is the newest bit. Per valid symbol, predicted pI = s[8]^s[4] and pQ = s[7]^s[3]. Shift in two bits (I first, then Q), so Q ends in s[0].
- Shifted-in bits are the received bits in SEARCH and CHECK (self-sync), and the predicted bits in LOCKED (free-running reference).
- in_valid==0: no state, register or counter changes; loss_pulse=0.
- SEARCH: count valid symbols. After LOAD_SYM of them, go to CHECK with the consecutive counter at 0.
- CHECK: a symbol with pI==bI and pQ==bQ increments the consecutive counter. Any mismatch clears it and returns to SEARCH with the load counter at 0. When the counter reaches LOCK_CNT, go to LOCKED, clearing the window counter and window error count.
- LOCKED, per valid symbol: mismatches m = (pI!=bI)+(pQ!=bQ), 0..2.
  - bit_cnt += 2 and err_cnt += m, each saturating at 2^CNT_W-1 (no wrap).
  - The window error count also accumulates m, saturating.
  - The window counter increments. On the WIN_LEN-th symbol, compare the window error count including the current m. If it exceeds ERR_THR: go to SEARCH and pulse loss_pulse for one cycle. Otherwise clear the window counter and window error count and stay in LOCKED.
- clear==1: bit_cnt=0 and err_cnt=0 that cycle. Clear wins over a simultaneous increment.
- Latency: all outputs are registered and reflect a valid symbol on the clk edge that samples it. locked rises on the edge that samples the LOCK_CNT-th good CHECK symbol.
- bit_cnt/err_cnt keep their values across loss of lock. Only rst or clear zeroes them.

Optional Feature:
- Macro BER_ERASURE_EN.
- When defined, adds parameter DZ_THR (default 16) and output port erase_cnt (CNT_W).
  - In LOCKED, each valid sample with |x| < DZ_THR (compared using magnitude DWIDTH+1 bits wide, so -2^(DWIDTH-1) is handled) adds 1 to erase_cnt, saturating. Erased samples still go through the normal compare.
  - erase_cnt is cleared by rst and by clear.
- When undefined, the port, parameter and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Lock acquisition: PRBS9 seed 9'h1FF mapped to +/-100, sigma_scale=0, in_valid=1 continuously. locked=0 through the first 20 symbols and rises on the 21st (5+16). bit_cnt=0 before lock.
- Clean run: after lock, 1000 symbols. bit_cnt=2000, err_cnt=0, loss_pulse never asserted.
- Single error: invert the I sign of one locked symbol. err_cnt increments by exactly 1 and locked stays 1 (the free-running reference means no error multiplication).
- Burst loss: invert every Q bit for a full window (256 errors > 16). locked falls and loss_pulse fires once at that window end. Re-lock occurs 21 symbols after the clean stream resumes. bit_cnt/err_cnt are retained.
- Gaps and reset: toggle in_valid 1/0 every cycle. Lock occurs after 21 valid symbols, i.e. 42 cycles. Assert rst=0 for one cycle mid-lock: all outputs are 0 on the next edge and state returns to SEARCH.
- Saturation/clear: CNT_W=8 with in_valid=1, stream all-inverted once locked. err_cnt stops at 255 and does not wrap. clear=1 on the same cycle as an increment leaves bit_cnt=0 and err_cnt=0.

Source files
------------

// File: rtl/prbs_qpsk_ber_checker.sv
// prbs_qpsk_ber_checker: QPSK hard slicer with a self-synchronising PRBS9 reference and BER counters.
// Optional macro BER_ERASURE_EN adds DZ_THR and a dead-zone erasure counter (erase_cnt).
`default_nettype none

module prbs_qpsk_ber_checker #(
   parameter int DWIDTH   = 9,
   parameter int CNT_W    = 32,
   parameter int LOAD_SYM = 5,
   parameter int LOCK_CNT = 16,
   parameter int WIN_LEN  = 256,
   parameter int ERR_THR  = 16
`ifdef BER_ERASURE_EN
   , parameter int DZ_THR = 16
`endif
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DWIDTH-1:0] In_I,
   input  logic [DWIDTH-1:0] In_Q,
   input  logic              clear,
   output logic              locked,
   output logic [CNT_W-1:0]  bit_cnt,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              loss_pulse
`ifdef BER_ERASURE_EN
   , output logic [CNT_W-1:0] erase_cnt
`endif
);

   localparam int LD_W = $clog2(LOAD_SYM + 1);
   localparam int LK_W = $clog2(LOCK_CNT + 1);
   localparam int WC_W = $clog2(WIN_LEN + 1);
   localparam int WE_W = $clog2(2 * WIN_LEN + ERR_THR + 2);

   localparam logic [LD_W-1:0]  c_LOAD_LAST = LD_W'(LOAD_SYM - 1);
   localparam logic [LK_W-1:0]  c_LOCK_LAST = LK_W'(LOCK_CNT - 1);
   localparam logic [WC_W-1:0]  c_WIN_LAST  = WC_W'(WIN_LEN - 1);
   localparam logic [WE_W-1:0]  c_ERR_THR   = WE_W'(ERR_THR);
   localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;
   localparam logic [WE_W-1:0]  c_WE_MAX    = '1;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_CHECK  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t          r_state;
   logic [8:0]      r_s;
   logic [LD_W-1:0] r_load_cnt;
   logic [LK_W-1:0] r_cons_cnt;
   logic [WC_W-1:0] r_win_cnt;
   logic [WE_W-1:0] r_win_err;

   logic            w_bi, w_bq, w_pi, w_pq, w_ei, w_eq, w_match;
   logic [1:0]      w_m;
   logic [CNT_W:0]  w_bit_sum, w_err_sum;
   logic [CNT_W-1:0] w_bit_nxt, w_err_nxt;
   logic [WE_W:0]   w_we_sum;
   logic [WE_W-1:0] w_we_nxt;
   logic            w_win_last, w_win_bad;

   assign w_bi    = In_I[DWIDTH-1];
   assign w_bq    = In_Q[DWIDTH-1];
   assign w_pi    = r_s[8] ^ r_s[4];
   assign w_pq    = r_s[7] ^ r_s[3];
   assign w_ei    = w_pi ^ w_bi;
   assign w_eq    = w_pq ^ w_bq;
   assign w_match = ~(w_ei | w_eq);
   assign w_m     = {1'b0, w_ei} + {1'b0, w_eq};

   // One extra carry bit on each sum detects overflow for saturation.
   assign w_bit_sum = {1'b0, bit_cnt} + (CNT_W+1)'(2);
   assign w_err_sum = {1'b0, err_cnt} + {{(CNT_W-1){1'b0}}, w_m};
   assign w_bit_nxt = w_bit_sum[CNT_W] ? c_CNT_MAX : w_bit_sum[CNT_W-1:0];
   assign w_err_nxt = w_err_sum[CNT_W] ? c_CNT_MAX : w_err_sum[CNT_W-1:0];

   assign w_we_sum   = {1'b0, r_win_err} + {{(WE_W-1){1'b0}}, w_m};
   assign w_we_nxt   = w_we_sum[WE_W] ? c_WE_MAX : w_we_sum[WE_W-1:0];
   assign w_win_last = (r_win_cnt == c_WIN_LAST);
   assign w_win_bad  = (w_we_nxt > c_ERR_THR);

`ifdef BER_ERASURE_EN
   localparam logic [DWIDTH:0] c_DZ_THR = (DWIDTH+1)'(DZ_THR);
   logic [DWIDTH:0]  w_xi, w_xq, w_mag_i, w_mag_q;
   logic [1:0]       w_er;
   logic [CNT_W:0]   w_ers_sum;
   logic [CNT_W-1:0] w_ers_nxt;

   // Magnitude is one bit wider so the most negative sample does not overflow.
   assign w_xi      = {In_I[DWIDTH-1], In_I};
   assign w_xq      = {In_Q[DWIDTH-1], In_Q};
   assign w_mag_i   = w_xi[DWIDTH] ? (~w_xi + 1'b1) : w_xi;
   assign w_mag_q   = w_xq[DWIDTH] ? (~w_xq + 1'b1) : w_xq;
   assign w_er      = {1'b0, (w_mag_i < c_DZ_THR)} + {1'b0, (w_mag_q < c_DZ_THR)};
   assign w_ers_sum = {1'b0, erase_cnt} + {{(CNT_W-1){1'b0}}, w_er};
   assign w_ers_nxt = w_ers_sum[CNT_W] ? c_CNT_MAX : w_ers_sum[CNT_W-1:0];
`else
   logic w_unused;
   assign w_unused = &{1'b0, In_I[DWIDTH-2:0], In_Q[DWIDTH-2:0]};
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= ST_SEARCH;
         r_s        <= '0;
         r_load_cnt <= '0;
         r_cons_cnt <= '0;
         r_win_cnt  <= '0;
         r_win_err  <= '0;
         locked     <= 1'b0;
         bit_cnt    <= '0;
         err_cnt    <= '0;
         loss_pulse <= 1'b0;
`ifdef BER_ERASURE_EN
         erase_cnt  <= '0;
`endif
      end else begin
         loss_pulse <= 1'b0;
         if (in_valid) begin
            case (r_state)
               ST_SEARCH: begin
                  r_s <= {r_s[6:0], w_bi, w_bq};
                  if (r_load_cnt == c_LOAD_LAST) begin
                     r_state    <= ST_CHECK;
                     r_load_cnt <= '0;
                     r_cons_cnt <= '0;
                  end else begin
                     r_load_cnt <= r_load_cnt + 1'b1;
                  end
               end
               ST_CHECK: begin
                  r_s <= {r_s[6:0], w_bi, w_bq};
                  if (!w_match) begin
                     r_state    <= ST_SEARCH;
                     r_load_cnt <= '0;
                     r_cons_cnt <= '0;
                  end else if (r_cons_cnt == c_LOCK_LAST) begin
                     r_state   <= ST_LOCKED;
                     locked    <= 1'b1;
                     r_win_cnt <= '0;
                     r_win_err <= '0;
                  end else begin
                     r_cons_cnt <= r_cons_cnt + 1'b1;
                  end
               end
               ST_LOCKED: begin
                  // Free-running reference: a channel error never enters r_s.
                  r_s     <= {r_s[6:0], w_pi, w_pq};
                  bit_cnt <= w_bit_nxt;
                  err_cnt <= w_err_nxt;
`ifdef BER_ERASURE_EN
                  erase_cnt <= w_ers_nxt;
`endif
                  if (w_win_last) begin
                     r_win_cnt <= '0;
                     r_win_err <= '0;
                     if (w_win_bad) begin
                        r_state    <= ST_SEARCH;
                        locked     <= 1'b0;
                        loss_pulse <= 1'b1;
                        r_load_cnt <= '0;
                     end
                  end else begin
                     r_win_cnt <= r_win_cnt + 1'b1;
                     r_win_err <= w_we_nxt;
                  end
               end
               default: begin
                  r_state <= ST_SEARCH;
                  locked  <= 1'b0;
               end
            endcase
         end
         if (clear) begin
            bit_cnt <= '0;
            err_cnt <= '0;
`ifdef BER_ERASURE_EN
            erase_cnt <= '0;
`endif
         end
      end
   end

endmodule

`default_nettype wire
